pkt_arb: RTL and testbench

PKT_ARB -- requirements
Module: pkt_arb

---
 rtl/pkt_arb.sv | 167 ++++++++++++++++
 tb/tb_pkt_arb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_arb.sv
// Two-source packet arbiter with weighted round-robin or strict priority,
// merging byte streams onto one egress port behind a small CPU register file.
module pkt_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    input  logic       rw,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] rxd0,
    input  logic       rx_vld0,
    output logic       rdy0,
    input  logic [7:0] rxd1,
    input  logic       rx_vld1,
    output logic       rdy1,
    output logic [7:0] txd,
    output logic       tx_vld
);

    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER0 = 2'd1,
        XFER1 = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t         r_state;
    logic [DW-1:0]  r_ctrl;
    logic [DW-1:0]  r_weight0;
    logic [DW-1:0]  r_weight1;
    logic [DW-1:0]  r_cnt0;
    logic [DW-1:0]  r_cnt1;
    logic [DW-1:0]  r_cred;
    logic           r_last;

    logic           w_en;
    logic           w_strict;
    logic           w_busy;
    logic [1:0]     w_vld;
    logic           w_grant;
    logic           w_keep;
    logic [DW-1:0]  w_weight;
    logic [DW-1:0]  w_reload;
    logic [DW-1:0]  w_rdata;
    logic           w_clr0;
    logic           w_clr1;

    assign w_en     = r_ctrl[0];
    assign w_strict = r_ctrl[1];
    assign w_busy   = (r_state != IDLE);
    assign w_vld    = {rx_vld1, rx_vld0};
    assign w_clr0   = rw && (addr == 8'h03);
    assign w_clr1   = rw && (addr == 8'h04);

    // Winner selection; only consulted in IDLE when some source requests.
    always_comb begin
        w_grant = r_last;
        if (w_strict) begin
            w_grant = ~rx_vld0;
        end else if (w_vld[r_last] && (r_cred != '0)) begin
            w_grant = r_last;
        end else if (w_vld[~r_last]) begin
            w_grant = ~r_last;
        end
    end

    // Re-granting the last source spends a credit; anything else reloads.
    assign w_keep   = (w_grant == r_last) && (r_cred != '0);
    assign w_weight = w_grant ? r_weight1 : r_weight0;
    assign w_reload = (w_weight == '0) ? '0 : w_weight - DW'(1);

    always_comb begin
        w_rdata = '0;
        case (addr)
            8'h00:   w_rdata = r_ctrl;
            8'h01:   w_rdata = r_weight0;
            8'h02:   w_rdata = r_weight1;
            8'h03:   w_rdata = r_cnt0;
            8'h04:   w_rdata = r_cnt1;
            8'h05:   w_rdata = {6'b0, r_last, w_busy};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl    <= '0;
            r_weight0 <= DW'(1);
            r_weight1 <= DW'(1);
        end else if (rw) begin
            case (addr)
                8'h00:   r_ctrl    <= din;
                8'h01:   r_weight0 <= din;
                8'h02:   r_weight1 <= din;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (!rw) begin
            dout <= w_rdata;
        end
    end

    // Arbitration FSM, egress datapath and per-source packet counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cred  <= '0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
            rdy0    <= 1'b0;
            rdy1    <= 1'b0;
            txd     <= '0;
            tx_vld  <= 1'b0;
        end else begin
            tx_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_en && (|w_vld)) begin
                        r_state <= w_grant ? XFER1 : XFER0;
                        rdy0    <= ~w_grant;
                        rdy1    <= w_grant;
                        if (w_keep) begin
                            r_cred <= r_cred - DW'(1);
                        end else begin
                            r_cred <= w_reload;
                            r_last <= w_grant;
                        end
                    end
                end
                XFER0: begin
                    if (rx_vld0) begin
                        txd    <= rxd0;
                        tx_vld <= 1'b1;
                    end else begin
                        r_state <= GAP;
                        rdy0    <= 1'b0;
                        r_cnt0  <= r_cnt0 + DW'(1);
                    end
                end
                XFER1: begin
                    if (rx_vld1) begin
                        txd    <= rxd1;
                        tx_vld <= 1'b1;
                    end else begin
                        r_state <= GAP;
                        rdy1    <= 1'b0;
                        r_cnt1  <= r_cnt1 + DW'(1);
                    end
                end
                GAP:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            // A CPU clear beats a same-cycle packet-end increment.
            if (w_clr0) r_cnt0 <= '0;
            if (w_clr1) r_cnt1 <= '0;
        end
    end

endmodule

// File: tb/tb_pkt_arb.sv
// Self-checking bench for pkt_arb: scoreboard of expected egress bytes plus
// register readback, arbitration order, counter wrap and reset behaviour.
module tb_pkt_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = 8'h07;
    logic       rw = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic [7:0] rxd0 = 8'h00;
    logic       rx_vld0 = 1'b0;
    logic       rdy0;
    logic [7:0] rxd1 = 8'h00;
    logic       rx_vld1 = 1'b0;
    logic       rdy1;
    logic [7:0] txd;
    logic       tx_vld;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q[$];
    bit         abort = 1'b0;
    bit         watch = 1'b0;
    int         rdy1_hits = 0;

    pkt_arb dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .rw      (rw),
        .din     (din),
        .dout    (dout),
        .rxd0    (rxd0),
        .rx_vld0 (rx_vld0),
        .rdy0    (rdy0),
        .rxd1    (rxd1),
        .rx_vld1 (rx_vld1),
        .rdy1    (rdy1),
        .txd     (txd),
        .tx_vld  (tx_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; din = d; rw = 1'b1;
        @(posedge clk); #1;
        rw = 1'b0; addr = 8'h07;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr = a; rw = 1'b0;
        @(posedge clk); #1;
        check(tag, 32'(dout), 32'(exp));
        addr = 8'h07;
    endtask

    task automatic wait_rdy(input int s, output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 400; g++) begin
            @(negedge clk);
            if (abort) return;
            if ((s == 0) ? rdy0 : rdy1) begin
                ok = 1'b1;
                return;
            end
        end
        check("rdy_timeout", 32'(s), 32'hFFFF);
    endtask

    task automatic send0(input int n, input logic [7:0] base);
        bit ok;
        for (int i = 0; i < n; i++) begin
            rxd0 = base + 8'(i); rx_vld0 = 1'b1;
            wait_rdy(0, ok);
            if (!ok) break;
            @(posedge clk); #1;
        end
        rx_vld0 = 1'b0; rxd0 = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic send1(input int n, input logic [7:0] base);
        bit ok;
        for (int i = 0; i < n; i++) begin
            rxd1 = base + 8'(i); rx_vld1 = 1'b1;
            wait_rdy(1, ok);
            if (!ok) break;
            @(posedge clk); #1;
        end
        rx_vld1 = 1'b0; rxd1 = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        for (int g = 0; g < 3000 && q.size() != 0; g++) begin
            @(posedge clk); #1;
        end
        repeat (4) begin @(posedge clk); #1; end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Egress monitor: scoreboard pop, one-cycle latency and inter-packet gap.
    task automatic monitor();
        bit         prev_hs = 1'b0;
        bit         prev_vld = 1'b0;
        bit         seen = 1'b0;
        bit         hs;
        int         idle = 0;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                prev_hs = 1'b0; prev_vld = 1'b0; seen = 1'b0; idle = 0;
                continue;
            end
            hs = (rx_vld0 && rdy0) || (rx_vld1 && rdy1);
            if (tx_vld || prev_hs) check("latency", 32'(tx_vld), 32'(prev_hs));
            if (tx_vld) begin
                if (!prev_vld && seen) check("gap", 32'(idle >= 2), 32'd1);
                if (q.size() == 0) begin
                    check("tx_extra", 32'(txd), 32'h100);
                end else begin
                    exp = q.pop_front();
                    check("txd", 32'(txd), 32'(exp));
                end
                seen = 1'b1;
                idle = 0;
            end else begin
                idle++;
            end
            prev_vld = tx_vld;
            prev_hs  = hs;
            if (watch && rdy1) rdy1_hits++;
        end
    endtask

    initial begin
        int  base;
        bit  ok;
        fork monitor(); join_none

        // reset state
        #1;
        check("rst_tx_vld", 32'(tx_vld), 32'd0);
        check("rst_rdy0", 32'(rdy0), 32'd0);
        check("rst_rdy1", 32'(rdy1), 32'd0);
        check("rst_txd", 32'(txd), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_chk("rst_ctrl", 8'h00, 8'h00);
        rd_chk("rst_w0", 8'h01, 8'h01);
        rd_chk("rst_w1", 8'h02, 8'h01);
        rd_chk("rst_cnt0", 8'h03, 8'h00);
        rd_chk("rst_cnt1", 8'h04, 8'h00);
        rd_chk("rst_status", 8'h05, 8'h02);
        cpu_wr(8'h09, 8'hFF);
        rd_chk("unmapped_rd", 8'h09, 8'h00);
        rd_chk("unmapped_wr", 8'h00, 8'h00);

        // single 4-byte packet on source 0
        cpu_wr(8'h00, 8'h01);
        for (int i = 0; i < 4; i++) q.push_back(8'hA0 + 8'(i));
        send0(4, 8'hA0);
        wait_drain();
        rd_chk("cnt0_one", 8'h03, 8'h01);
        rd_chk("ctrl_rb", 8'h00, 8'h01);
        rd_chk("status_idle", 8'h05, 8'h00);

        // weighted round-robin 2:1 from fresh arbiter state
        do_reset();
        cpu_wr(8'h00, 8'h01);
        cpu_wr(8'h01, 8'h02);
        rd_chk("w0_rb", 8'h01, 8'h02);
        q.push_back(8'h10); q.push_back(8'h11); q.push_back(8'h20);
        q.push_back(8'h12); q.push_back(8'h13); q.push_back(8'h21);
        fork
            begin for (int i = 0; i < 4; i++) send0(1, 8'h10 + 8'(i)); end
            begin for (int i = 0; i < 2; i++) send1(1, 8'h20 + 8'(i)); end
        join
        wait_drain();
        rd_chk("cnt0_wrr", 8'h03, 8'h04);
        rd_chk("cnt1_wrr", 8'h04, 8'h02);

        // strict priority: source 1 starved while source 0 keeps requesting
        cpu_wr(8'h00, 8'h03);
        q.push_back(8'h30); q.push_back(8'h31); q.push_back(8'h32); q.push_back(8'h40);
        base = rdy1_hits;
        fork
            begin
                watch = 1'b1;
                for (int i = 0; i < 3; i++) send0(1, 8'h30 + 8'(i));
                watch = 1'b0;
            end
            send1(1, 8'h40);
        join
        check("strict_rdy1", 32'(rdy1_hits - base), 32'd0);
        wait_drain();
        cpu_wr(8'h00, 8'h01);

        // EN cleared mid-packet: packet completes, pending source waits
        for (int i = 0; i < 6; i++) q.push_back(8'h50 + 8'(i));
        q.push_back(8'h60);
        fork
            send0(6, 8'h50);
            begin wait_rdy(0, ok); send1(1, 8'h60); end
            begin
                wait_rdy(0, ok);
                @(posedge clk); #1;
                @(posedge clk); #1;
                base = rdy1_hits;
                watch = 1'b1;
                cpu_wr(8'h00, 8'h00);
                repeat (20) begin @(posedge clk); #1; end
                watch = 1'b0;
                check("en_off_rdy1", 32'(rdy1_hits - base), 32'd0);
                check("en_off_pending", 32'(q.size()), 32'd1);
                cpu_wr(8'h00, 8'h01);
            end
        join
        wait_drain();

        // packet counter wrap on source 1
        cpu_wr(8'h04, 8'h00);
        for (int i = 0; i < 255; i++) begin
            q.push_back(8'(i));
            send1(1, 8'(i));
        end
        wait_drain();
        rd_chk("cnt1_255", 8'h04, 8'hFF);
        q.push_back(8'hEE);
        send1(1, 8'hEE);
        wait_drain();
        rd_chk("cnt1_wrap", 8'h04, 8'h00);
        q.push_back(8'hC1);
        send1(1, 8'hC1);
        wait_drain();
        rd_chk("cnt1_one", 8'h04, 8'h01);

        // CPU clear coincident with packet end
        q.push_back(8'hC0);
        fork
            send1(1, 8'hC0);
            begin
                wait_rdy(1, ok);
                @(posedge clk); #1;
                cpu_wr(8'h04, 8'h00);
            end
        join
        wait_drain();
        rd_chk("cnt1_clr_wins", 8'h04, 8'h00);

        // reset asserted mid-packet
        cpu_wr(8'h01, 8'h05);
        for (int i = 0; i < 8; i++) q.push_back(8'h70 + 8'(i));
        fork
            send0(8, 8'h70);
            begin
                wait_rdy(0, ok);
                @(posedge clk);
                #3;
                check("pre_rst_vld", 32'(tx_vld), 32'd1);
                abort = 1'b1;
                rst_n = 1'b0;
                #1;
                check("async_tx_vld", 32'(tx_vld), 32'd0);
                check("async_rdy0", 32'(rdy0), 32'd0);
                check("async_rdy1", 32'(rdy1), 32'd0);
                check("async_txd", 32'(txd), 32'd0);
                check("async_dout", 32'(dout), 32'd0);
                #10;
                rst_n = 1'b1;
                @(posedge clk); #1;
            end
        join
        abort = 1'b0;
        rd_chk("rst2_ctrl", 8'h00, 8'h00);
        rd_chk("rst2_w0", 8'h01, 8'h01);
        rd_chk("rst2_w1", 8'h02, 8'h01);
        rd_chk("rst2_cnt0", 8'h03, 8'h00);
        rd_chk("rst2_cnt1", 8'h04, 8'h00);
        rd_chk("rst2_status", 8'h05, 8'h02);

        // source restarts its packet after reset
        cpu_wr(8'h00, 8'h01);
        q.push_back(8'h80); q.push_back(8'h81);
        send0(2, 8'h80);
        wait_drain();
        rd_chk("cnt0_restart", 8'h03, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
